// File: rtl/wb_debug_tap.sv
// Passive Wishbone snoop: filtered, acked transactions become {data, adr, we} records,
// buffered in a FIFO and streamed out OUT_W bits per beat under valid/ready.
module wb_debug_tap #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int OUT_W = 8,
  parameter int CNT_W = 8,
  localparam int REC_W = 1 + AW + DW,
  localparam int BEATS = (REC_W + OUT_W - 1) / OUT_W,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_dat_o,
  input  logic             wbs_ack_o,
  input  logic             enable,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [31:0]      addr_base,
  input  logic [31:0]      addr_mask,
  output logic [OUT_W-1:0] dbg_out,
  output logic             dbg_valid,
  output logic             dbg_first,
  output logic             dbg_last,
  input  logic             dbg_ready,
  output logic [LW-1:0]    fifo_level,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int PW   = $clog2(DEPTH);
  localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SR_W = BEATS * OUT_W;

  typedef enum logic {S_IDLE, S_SEND} state_t;
  state_t state;

  logic [REC_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic [BW-1:0]    beat, beat_nx;
  logic [SR_W-1:0]  frame, head_pad;
  logic [31:0]      dat_sel;
  logic             match, mode_ok, cap, full, push, pop, drop, xfer;
  logic             unused_dat;

  // Data field follows the bus direction: write data on writes, slave read data on reads.
  assign dat_sel    = wbs_we_i ? wbs_dat_i : wbs_dat_o;
  assign unused_dat = ^dat_sel;
  assign match      = ((wbs_adr_i ^ addr_base) & addr_mask) == '0;
  assign mode_ok    = wbs_we_i ? mode[0] : mode[1];
  assign cap        = enable & wbs_cyc_i & wbs_stb_i & wbs_ack_o & match & mode_ok & ~clear;

  // The serializer pulls a record when idle or when the last beat of a frame leaves;
  // that pop frees a slot in time for a same-edge push into a full FIFO.
  assign full       = count == LW'(DEPTH);
  assign xfer       = dbg_valid & dbg_ready;
  assign pop        = (count != '0) & ((state == S_IDLE) | (xfer & dbg_last));
  assign push       = cap & (~full | pop);
  assign drop       = cap & full & ~pop;
  assign head_pad   = SR_W'(mem[rd_ptr]);
  assign beat_nx    = beat + BW'(1);
  assign fifo_level = count;

  // FIFO storage and frame shifter carry data only; no reset needed.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {dat_sel[DW-1:0], wbs_adr_i[AW-1:0], wbs_we_i};
    if (pop) frame <= head_pad >> OUT_W;
    else if (xfer) frame <= frame >> OUT_W;
  end

  always_ff @(posedge clock) begin
    if (!resetb || clear) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      beat      <= '0;
      dbg_out   <= '0;
      dbg_valid <= 1'b0;
      dbg_first <= 1'b0;
      dbg_last  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + LW'(push) - LW'(pop);
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);

      if (pop) begin
        state     <= S_SEND;
        beat      <= '0;
        dbg_out   <= head_pad[OUT_W-1:0];
        dbg_valid <= 1'b1;
        dbg_first <= 1'b1;
        dbg_last  <= (BEATS == 1);
      end else if (state == S_SEND && xfer) begin
        if (dbg_last) begin
          state     <= S_IDLE;
          dbg_out   <= '0;
          dbg_valid <= 1'b0;
          dbg_first <= 1'b0;
          dbg_last  <= 1'b0;
        end else begin
          beat      <= beat_nx;
          dbg_out   <= frame[OUT_W-1:0];
          dbg_first <= 1'b0;
          dbg_last  <= (beat_nx == BW'(BEATS - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_debug_tap.sv
// Bench for wb_debug_tap: directed scenarios plus a randomized run against a queue-based model.
module tb_wb_debug_tap;
  localparam int AW = 16, DW = 16, DEPTH = 8, OUT_W = 8, CNT_W = 8;
  localparam int REC_W = 1 + AW + DW;
  localparam int BEATS = (REC_W + OUT_W - 1) / OUT_W;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int MAXD = (1 << CNT_W) - 1;

  logic clock, resetb;
  logic wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic enable, clear, dbg_ready;
  logic [1:0] mode;
  logic [31:0] addr_base, addr_mask;
  logic [OUT_W-1:0] dbg_out;
  logic dbg_valid, dbg_first, dbg_last;
  logic [LW-1:0] fifo_level;
  logic [CNT_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  wb_debug_tap #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetb(resetb),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .enable(enable), .clear(clear), .mode(mode), .addr_base(addr_base), .addr_mask(addr_mask),
    .dbg_out(dbg_out), .dbg_valid(dbg_valid), .dbg_first(dbg_first), .dbg_last(dbg_last),
    .dbg_ready(dbg_ready), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  function automatic longint rec_of(bit we, logic [31:0] adr, logic [31:0] dat);
    return longint'(we) | (longint'(adr[AW-1:0]) << 1) | (longint'(dat[DW-1:0]) << (AW + 1));
  endfunction

  // Reference model: a record queue, one in-flight frame and a saturating drop count.
  longint mq[$];
  longint m_cur = 0;
  int     m_beat = 0;
  bit     m_busy = 1'b0;
  int     m_drops = 0;

  always @(posedge clock) begin : model
    bit ev, done;
    longint rec;
    ev = enable && wbs_cyc_i && wbs_stb_i && wbs_ack_o &&
         ((wbs_adr_i & addr_mask) == (addr_base & addr_mask)) &&
         (wbs_we_i ? mode[0] : mode[1]);
    rec = rec_of(wbs_we_i, wbs_adr_i, wbs_we_i ? wbs_dat_i : wbs_dat_o);
    if (!resetb || clear) begin
      mq.delete();
      m_busy = 1'b0;
      m_beat = 0;
      m_drops = 0;
    end else begin
      done = !m_busy || (dbg_ready && m_beat == BEATS - 1);
      if (done && mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_beat = 0;
        m_busy = 1'b1;
      end else if (done) begin
        m_busy = 1'b0;
      end else if (dbg_ready) begin
        m_beat++;
      end
      if (ev) begin
        if (mq.size() < DEPTH) mq.push_back(rec);
        else if (m_drops < MAXD) m_drops++;
      end
    end
  end

  // Frame reassembly from the debug port, keyed on dbg_first / dbg_last.
  longint got_q[$];
  longint mon_acc = 0;
  int     mon_idx = 0;
  int     mon_bad = 0;

  always @(negedge clock) begin
    if (resetb && dbg_valid && dbg_ready) begin
      if (dbg_first) begin
        mon_acc = 0;
        mon_idx = 0;
      end
      mon_acc = mon_acc | (longint'(dbg_out) << (mon_idx * OUT_W));
      mon_idx++;
      if (dbg_last) begin
        if (mon_idx == BEATS) got_q.push_back(mon_acc);
        else mon_bad++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_ack_o = 0; wbs_we_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0; wbs_dat_o = 0;
  endtask

  task automatic bus_xfer(bit w, logic [31:0] a, logic [31:0] di, logic [31:0] dro);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_ack_o = 1; wbs_we_i = w;
    wbs_adr_i = a; wbs_dat_i = di; wbs_dat_o = dro;
  endtask

  task automatic test_reset();
    resetb = 0; clear = 0; enable = 0; mode = 0; addr_base = 0; addr_mask = 0; dbg_ready = 1;
    bus_idle();
    tick(); tick();
    @(negedge clock);
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dbg_valid); end
    checks++; if (dbg_first !== 1'b0) begin errors++; $display("FAIL reset_first: got %b want 0", dbg_first); end
    checks++; if (dbg_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", dbg_last); end
    checks++; if (dbg_out !== '0) begin errors++; $display("FAIL reset_out: got %h want 00", dbg_out); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    tick();
    resetb = 1;
    tick();
  endtask

  task automatic test_basic_write();
    logic [7:0] exp_b [5];
    exp_b = '{8'h09, 8'h00, 8'hDE, 8'h7D, 8'h01};
    enable = 1; mode = 2'b11; addr_base = 0; addr_mask = 0; dbg_ready = 1;
    bus_xfer(1, 32'h3000_0004, 32'h0000_BEEF, 32'h0);
    @(negedge clock);
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_t0: got %b want 0", dbg_valid); end
    tick();
    bus_idle();
    @(negedge clock);
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_t1: got %b want 0", dbg_valid); end
    checks++; if (fifo_level !== LW'(1)) begin errors++; $display("FAIL basic_level_t1: got %0d want 1", fifo_level); end
    tick();
    for (int b = 0; b < 5; b++) begin
      @(negedge clock);
      checks++; if (dbg_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_beat%0d: got %b want 1", b, dbg_valid); end
      checks++; if (dbg_out !== exp_b[b]) begin errors++; $display("FAIL basic_out_beat%0d: got %h want %h", b, dbg_out, exp_b[b]); end
      checks++; if (dbg_first !== (b == 0)) begin errors++; $display("FAIL basic_first_beat%0d: got %b want %b", b, dbg_first, (b == 0)); end
      checks++; if (dbg_last !== (b == 4)) begin errors++; $display("FAIL basic_last_beat%0d: got %b want %b", b, dbg_last, (b == 4)); end
      tick();
    end
    @(negedge clock);
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_end: got %b want 0", dbg_valid); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL basic_level_end: got %0d want 0", fifo_level); end
    tick();
  endtask

  task automatic test_mode_filter();
    longint exp;
    enable = 1; addr_base = 0; addr_mask = 0; dbg_ready = 1;
    for (int m = 1; m <= 2; m++) begin
      mode = 2'(m);
      got_q.delete();
      bus_xfer(0, 32'h3000_0020, 32'hAAAA_5555, 32'h1234_5678); tick();
      bus_xfer(1, 32'h3000_0024, 32'hCAFE_F00D, 32'h1111_2222); tick();
      bus_idle();
      repeat (16) tick();
      exp = (m == 1) ? rec_of(1, 32'h3000_0024, 32'hCAFE_F00D) : rec_of(0, 32'h3000_0020, 32'h1234_5678);
      checks++; if (got_q.size() != 1) begin errors++; $display("FAIL mode%0d_count: got %0d records want 1", m, got_q.size()); end
      checks++;
      if (got_q.size() == 0 || got_q[0] != exp) begin
        errors++; $display("FAIL mode%0d_record: got %h want %h", m, (got_q.size() > 0) ? got_q[0] : 64'h0, exp);
      end
    end
    mode = 2'b00;
    got_q.delete();
    bus_xfer(1, 32'h3000_0028, 32'h0000_1357, 32'h0); tick();
    bus_xfer(0, 32'h3000_002C, 32'h0, 32'h0000_2468); tick();
    bus_idle();
    repeat (12) tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mode0_count: got %0d records want 0", got_q.size()); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL mode0_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_addr_filter();
    enable = 1; mode = 2'b11; addr_base = 32'h3000_0000; addr_mask = 32'hFFFF_0000; dbg_ready = 1;
    got_q.delete();
    bus_xfer(1, 32'h3000_0010, 32'h0000_A5A5, 32'h0); tick();
    bus_xfer(1, 32'h3001_0010, 32'h0000_5A5A, 32'h0); tick();
    bus_idle();
    repeat (16) tick();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL addr_count: got %0d records want 1", got_q.size()); end
    checks++;
    if (got_q.size() == 0 || ((got_q[0] >> 1) & 64'hFFFF) != 64'h0010) begin
      errors++; $display("FAIL addr_field: got %h want 0010", (got_q.size() > 0) ? ((got_q[0] >> 1) & 64'hFFFF) : 64'h0);
    end
    checks++;
    if (got_q.size() == 0 || got_q[0] != rec_of(1, 32'h3000_0010, 32'h0000_A5A5)) begin
      errors++; $display("FAIL addr_record: got %h want %h", (got_q.size() > 0) ? got_q[0] : 64'h0, rec_of(1, 32'h3000_0010, 32'h0000_A5A5));
    end
    addr_base = 0; addr_mask = 0;
  endtask

  task automatic test_back_to_back();
    int bubbles;
    enable = 1; mode = 2'b11; addr_mask = 0; dbg_ready = 0;
    got_q.delete();
    for (int i = 0; i < 10; i++) begin
      bus_xfer(1, 32'h100 + 32'(i), 32'h1000 + 32'(i), 32'h0);
      tick();
    end
    bus_idle();
    @(negedge clock);
    checks++; if (fifo_level !== LW'(8)) begin errors++; $display("FAIL bp_level: got %0d want 8", fifo_level); end
    checks++; if (drop_cnt !== CNT_W'(1)) begin errors++; $display("FAIL bp_drop: got %0d want 1", drop_cnt); end
    checks++; if (dbg_valid !== 1'b1 || dbg_first !== 1'b1) begin errors++; $display("FAIL bp_hold_flags: got valid=%b first=%b want 1 1", dbg_valid, dbg_first); end
    checks++; if (dbg_out !== 8'(rec_of(1, 32'h100, 32'h1000))) begin errors++; $display("FAIL bp_hold_out: got %h want %h", dbg_out, 8'(rec_of(1, 32'h100, 32'h1000))); end
    tick();
    dbg_ready = 1;
    bubbles = 0;
    for (int c = 0; c < 9 * BEATS; c++) begin
      @(negedge clock);
      if (dbg_valid !== 1'b1) bubbles++;
      tick();
    end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL bp_bubbles: got %0d idle cycles want 0", bubbles); end
    @(negedge clock);
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_end: got %b want 0", dbg_valid); end
    checks++; if (got_q.size() != 9) begin errors++; $display("FAIL bp_count: got %0d records want 9", got_q.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] != rec_of(1, 32'h100 + 32'(i), 32'h1000 + 32'(i))) begin
        errors++; $display("FAIL bp_record%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 64'h0, rec_of(1, 32'h100 + 32'(i), 32'h1000 + 32'(i)));
      end
    end
    tick();
  endtask

  task automatic test_clear();
    logic [7:0] b2;
    enable = 1; mode = 2'b11; addr_mask = 0; dbg_ready = 1;
    b2 = 8'(rec_of(1, 32'h40, 32'h2000) >> 16);
    for (int i = 0; i < 4; i++) begin
      bus_xfer(1, 32'h40 + 32'(i), 32'h2000 + 32'(i), 32'h0);
      tick();
    end
    clear = 1;
    bus_xfer(1, 32'h50, 32'h2222, 32'h0);
    @(negedge clock);
    checks++; if (dbg_valid !== 1'b1 || dbg_first !== 1'b0 || dbg_out !== b2) begin errors++; $display("FAIL clear_pre_beat2: got valid=%b first=%b out=%h want 1 0 %h", dbg_valid, dbg_first, dbg_out, b2); end
    checks++; if (fifo_level !== LW'(3)) begin errors++; $display("FAIL clear_pre_level: got %0d want 3", fifo_level); end
    tick();
    clear = 0;
    bus_idle();
    @(negedge clock);
    checks++; if (dbg_valid !== 1'b0) begin errors++; $display("FAIL clear_valid: got %b want 0", dbg_valid); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL clear_level: got %0d want 0", fifo_level); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL clear_drop: got %0d want 0", drop_cnt); end
    tick(); tick();
    @(negedge clock);
    checks++; if (dbg_valid !== 1'b0 || fifo_level !== '0) begin errors++; $display("FAIL clear_discard: got valid=%b level=%0d want 0 0", dbg_valid, fifo_level); end
    tick();
    got_q.delete();
    mon_bad = 0;
    bus_xfer(1, 32'h60, 32'h3333, 32'h0); tick();
    bus_idle();
    repeat (10) tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] != rec_of(1, 32'h60, 32'h3333) || mon_bad != 0) begin
      errors++; $display("FAIL clear_next_frame: got %0d records first=%h bad=%0d want 1 %h 0", got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'h0, mon_bad, rec_of(1, 32'h60, 32'h3333));
    end
  endtask

  task automatic test_reset_midframe();
    enable = 1; mode = 2'b11; addr_mask = 0; dbg_ready = 1;
    bus_xfer(1, 32'h70, 32'h4444, 32'h0); tick();
    bus_xfer(1, 32'h74, 32'h5555, 32'h0); tick();
    bus_idle(); tick();
    resetb = 0;
    @(negedge clock);
    checks++; if (dbg_valid !== 1'b1 || dbg_first !== 1'b0) begin errors++; $display("FAIL rstmid_pre: got valid=%b first=%b want 1 0", dbg_valid, dbg_first); end
    tick();
    resetb = 1;
    @(negedge clock);
    checks++;
    if (dbg_valid !== 1'b0 || dbg_first !== 1'b0 || dbg_last !== 1'b0 || dbg_out !== '0 || fifo_level !== '0 || drop_cnt !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got valid=%b first=%b last=%b out=%h level=%0d drop=%0d want all 0", dbg_valid, dbg_first, dbg_last, dbg_out, fifo_level, drop_cnt);
    end
    tick();
    dbg_ready = 0;
    for (int i = 0; i < 309; i++) begin
      bus_xfer(1, 32'h80, 32'(i), 32'h0);
      @(negedge clock);
      if (i == 263) begin
        checks++; if (drop_cnt !== CNT_W'(254)) begin errors++; $display("FAIL sat_drop_254: got %0d want 254", drop_cnt); end
      end
      if (i == 264) begin
        checks++; if (drop_cnt !== CNT_W'(255)) begin errors++; $display("FAIL sat_drop_255: got %0d want 255", drop_cnt); end
      end
      tick();
    end
    bus_idle();
    @(negedge clock);
    checks++; if (drop_cnt !== CNT_W'(255)) begin errors++; $display("FAIL sat_drop_hold: got %0d want 255", drop_cnt); end
    checks++; if (fifo_level !== LW'(8)) begin errors++; $display("FAIL sat_level: got %0d want 8", fifo_level); end
    tick();
    clear = 1; dbg_ready = 1; tick();
    clear = 0; tick();
  endtask

  task automatic test_random();
    logic [7:0] eb;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        addr_mask = 32'($urandom_range(0, 3));
        addr_base = $urandom;
      end
      enable    = ($urandom_range(0, 7) != 0);
      mode      = 2'($urandom_range(0, 3));
      wbs_cyc_i = ($urandom_range(0, 7) != 0);
      wbs_stb_i = ($urandom_range(0, 7) != 0);
      wbs_ack_o = ($urandom_range(0, 1) != 0);
      wbs_we_i  = ($urandom_range(0, 1) != 0);
      wbs_adr_i = $urandom;
      wbs_dat_i = $urandom;
      wbs_dat_o = $urandom;
      dbg_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 63) == 0);
      resetb    = ($urandom_range(0, 127) != 0);
      @(negedge clock);
      eb = 8'(m_cur >> (m_beat * OUT_W));
      checks++; if (dbg_valid !== m_busy) begin errors++; $display("FAIL rnd_valid cyc%0d: got %b want %b", i, dbg_valid, m_busy); end
      if (m_busy) begin
        checks++; if (dbg_out !== eb) begin errors++; $display("FAIL rnd_out cyc%0d: got %h want %h", i, dbg_out, eb); end
        checks++; if (dbg_first !== (m_beat == 0)) begin errors++; $display("FAIL rnd_first cyc%0d: got %b want %b", i, dbg_first, (m_beat == 0)); end
        checks++; if (dbg_last !== (m_beat == BEATS - 1)) begin errors++; $display("FAIL rnd_last cyc%0d: got %b want %b", i, dbg_last, (m_beat == BEATS - 1)); end
      end
      checks++; if (fifo_level !== LW'(mq.size())) begin errors++; $display("FAIL rnd_level cyc%0d: got %0d want %0d", i, fifo_level, mq.size()); end
      checks++; if (drop_cnt !== CNT_W'(m_drops)) begin errors++; $display("FAIL rnd_drop cyc%0d: got %0d want %0d", i, drop_cnt, m_drops); end
      tick();
    end
    bus_idle();
    resetb = 1; clear = 1; tick();
    clear = 0; tick();
  endtask

  initial begin
    resetb = 0; clear = 0; enable = 0; mode = 0; addr_base = 0; addr_mask = 0; dbg_ready = 1;
    bus_idle();
    test_reset();
    test_basic_write();
    test_mode_filter();
    test_addr_filter();
    test_back_to_back();
    test_clear();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
